// File: rtl/path_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | path_sched: Monte Carlo path scheduler feeding a pipelined price        |
// | generator and accumulating call payoffs.              Revision: 1.0     |
// +------------------------------------------------------------------------+
module path_sched #(
  parameter int LAT   = 3,
  parameter int ACC_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_paths,
  input  logic [9:0]       num_days,
  input  logic [11:0]      strike,
  input  logic             eps_valid,
  input  logic [12:0]      eps_data,
  output logic             eps_ready,
  output logic [12:0]      pg_epsilon,
  output logic             pg_issue,
  output logic             pg_first_day,
  input  logic [11:0]      pg_result,
  output logic             res_valid,
  output logic [11:0]      res_price,
  output logic [15:0]      res_path_idx,
  output logic [ACC_W-1:0] payoff_sum,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [15:0]      np_q, np_d;
  logic [9:0]       nd_q, nd_d;
  logic [11:0]      strike_q, strike_d;
  logic [9:0]       day_q, day_d;
  logic [15:0]      path_q, path_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             eps_ready_q, eps_ready_d;
  logic [12:0]      pg_epsilon_q, pg_epsilon_d;
  logic             pg_issue_q, pg_issue_d;
  logic             pg_first_day_q, pg_first_day_d;
  logic             res_valid_q, res_valid_d;
  logic [11:0]      res_price_q, res_price_d;
  logic [15:0]      res_path_idx_q, res_path_idx_d;
  logic [ACC_W-1:0] payoff_q, payoff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic        zero_run;
  logic        handshake;
  logic        wait_done;
  logic        last_day;
  logic        last_path;
  logic [11:0] excess;

  assign zero_run  = (num_paths == 16'd0) || (num_days == 10'd0);
  assign handshake = (state_q == S_ISSUE) && eps_valid && eps_ready_q;
  assign wait_done = (state_q == S_WAIT) && (wait_cnt_q == LAT_C);
  assign last_day  = (day_q == nd_q - 10'd1);
  assign last_path = (path_q == np_q - 16'd1);
  assign excess    = (pg_result > strike_q) ? (pg_result - strike_q) : 12'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = zero_run ? S_DONE : S_ISSUE;
      S_ISSUE: if (handshake) state_d = S_WAIT;
      S_WAIT:  if (wait_done) state_d = (last_day && last_path) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they line up with the state register.
  always_comb begin
    np_d           = np_q;
    nd_d           = nd_q;
    strike_d       = strike_q;
    day_d          = day_q;
    path_d         = path_q;
    wait_cnt_d     = wait_cnt_q;
    pg_epsilon_d   = pg_epsilon_q;
    res_price_d    = res_price_q;
    res_path_idx_d = res_path_idx_q;
    payoff_d       = payoff_q;
    pg_issue_d     = 1'b0;
    pg_first_day_d = 1'b0;
    res_valid_d    = 1'b0;
    eps_ready_d    = (state_d == S_ISSUE);
    busy_d         = (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d         = (state_d == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          np_d     = num_paths;
          nd_d     = num_days;
          strike_d = strike;
          payoff_d = '0;
          day_d    = 10'd0;
          path_d   = 16'd0;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          pg_epsilon_d   = eps_data;
          pg_issue_d     = 1'b1;
          pg_first_day_d = (day_q == 10'd0);
          wait_cnt_d     = '0;
        end
      end
      S_WAIT: begin
        if (!wait_done) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else if (last_day) begin
          res_valid_d    = 1'b1;
          res_price_d    = pg_result;
          res_path_idx_d = path_q;
          payoff_d       = payoff_q + ACC_W'(excess);
          day_d          = 10'd0;
          path_d         = path_q + 16'd1;
        end else begin
          day_d = day_q + 10'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      np_q           <= '0;
      nd_q           <= '0;
      strike_q       <= '0;
      day_q          <= '0;
      path_q         <= '0;
      wait_cnt_q     <= '0;
      eps_ready_q    <= 1'b0;
      pg_epsilon_q   <= '0;
      pg_issue_q     <= 1'b0;
      pg_first_day_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_price_q    <= '0;
      res_path_idx_q <= '0;
      payoff_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      np_q           <= np_d;
      nd_q           <= nd_d;
      strike_q       <= strike_d;
      day_q          <= day_d;
      path_q         <= path_d;
      wait_cnt_q     <= wait_cnt_d;
      eps_ready_q    <= eps_ready_d;
      pg_epsilon_q   <= pg_epsilon_d;
      pg_issue_q     <= pg_issue_d;
      pg_first_day_q <= pg_first_day_d;
      res_valid_q    <= res_valid_d;
      res_price_q    <= res_price_d;
      res_path_idx_q <= res_path_idx_d;
      payoff_q       <= payoff_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign eps_ready    = eps_ready_q;
  assign pg_epsilon   = pg_epsilon_q;
  assign pg_issue     = pg_issue_q;
  assign pg_first_day = pg_first_day_q;
  assign res_valid    = res_valid_q;
  assign res_price    = res_price_q;
  assign res_path_idx = res_path_idx_q;
  assign payoff_sum   = payoff_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_path_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_path_sched: self-checking bench for path_sched with a price          |
// | generator model and a per-run payoff reference.       Revision: 1.0     |
// +------------------------------------------------------------------------+
module tb_path_sched;
  localparam int LAT   = 3;
  localparam int ACC_W = 28;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      num_paths;
  logic [9:0]       num_days;
  logic [11:0]      strike;
  logic             eps_valid;
  logic [12:0]      eps_data;
  logic             eps_ready;
  logic [12:0]      pg_epsilon;
  logic             pg_issue;
  logic             pg_first_day;
  logic [11:0]      pg_result;
  logic             res_valid;
  logic [11:0]      res_price;
  logic [15:0]      res_path_idx;
  logic [ACC_W-1:0] payoff_sum;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  path_sched #(.LAT(LAT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_paths(num_paths), .num_days(num_days),
    .strike(strike), .eps_valid(eps_valid), .eps_data(eps_data), .eps_ready(eps_ready),
    .pg_epsilon(pg_epsilon), .pg_issue(pg_issue), .pg_first_day(pg_first_day),
    .pg_result(pg_result), .res_valid(res_valid), .res_price(res_price),
    .res_path_idx(res_path_idx), .payoff_sum(payoff_sum), .busy(busy), .done(done)
  );

  // One generator step: the sample moves the price up or down by its magnitude.
  function automatic logic [11:0] step(input logic [11:0] base, input logic [12:0] e);
    return e[12] ? (base - e[11:0]) : (base + e[11:0]);
  endfunction

  task automatic run_case(input int np, input int nd, input logic [11:0] s0, input logic [11:0] k,
                          input int eps_max, input int valid_pct, input int stall,
                          input bit restart, input int abort_at,
                          output int first_iss, output int done_cyc);
    logic [12:0]      eps_q[$];
    logic [11:0]      fin[$];
    logic [ACC_W-1:0] psum[$];
    logic [ACC_W-1:0] total;
    logic [11:0]      price;
    logic [11:0]      gp;
    int n_eps, n_res, ei, issues, results, last_iss, due, cyc;
    bit finished;

    n_eps = (np == 0 || nd == 0) ? 0 : np * nd;
    n_res = (n_eps == 0) ? 0 : np;
    total = '0;
    for (int i = 0; i < n_eps; i++)
      eps_q.push_back({1'($urandom_range(0, 1)), 12'($urandom_range(0, eps_max))});
    for (int p = 0; p < n_res; p++) begin
      price = s0;
      for (int d = 0; d < nd; d++) price = step(price, eps_q[p*nd + d]);
      fin.push_back(price);
      if (price > k) total = total + ACC_W'(price - k);
      psum.push_back(total);
    end

    first_iss = -1; done_cyc = -1; gp = '0; ei = 0; issues = 0; results = 0;
    last_iss = -100; due = -1; finished = 0;
    @(negedge clk);
    num_paths = 16'(np); num_days = 10'(nd); strike = k; start = 1'b1; eps_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (pg_issue === 1'b1) begin
        checks++;
        if (issues >= n_eps) begin
          errors++;
          $display("FAIL extra_issue: issue %0d seen, only %0d expected", issues + 1, n_eps);
        end else begin
          if (pg_first_day !== (issues % nd == 0)) begin
            errors++;
            $display("FAIL first_day: issue %0d got %b", issues, pg_first_day);
          end
          checks++;
          if (pg_epsilon !== eps_q[issues]) begin
            errors++;
            $display("FAIL epsilon: issue %0d got %h expected %h", issues, pg_epsilon, eps_q[issues]);
          end
          if (issues > 0) begin
            checks++;
            if ((valid_pct == 100) ? (cyc - last_iss != LAT + 2) : (cyc - last_iss < LAT + 2)) begin
              errors++;
              $display("FAIL issue_spacing: got %0d cycles, required %0d", cyc - last_iss, LAT + 2);
            end
          end
        end
        gp = step(pg_first_day ? s0 : gp, pg_epsilon);
        due = cyc + LAT;
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        issues++;
        if (abort_at > 0 && issues == abort_at) begin
          rst = 1'b1;
          return;
        end
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (results >= n_res) begin
          errors++;
          $display("FAIL extra_result: result %0d seen, only %0d expected", results + 1, n_res);
        end else if (res_path_idx !== 16'(results) || res_price !== fin[results] ||
                     payoff_sum !== psum[results]) begin
          errors++;
          $display("FAIL result: idx %0d price %h sum %h, expected idx %0d price %h sum %h",
                   res_path_idx, res_price, payoff_sum, results, fin[results], psum[results]);
        end
        results++;
      end
      checks++;
      if (done === 1'b1) begin
        finished = 1; done_cyc = cyc;
        if (busy !== 1'b0 || results != n_res || issues != n_eps || payoff_sum !== total) begin
          errors++;
          $display("FAIL done_state: busy %b results %0d issues %0d sum %h, expected 0 %0d %0d %h",
                   busy, results, issues, payoff_sum, n_res, n_eps, total);
        end
      end else if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_run: cycle %0d got %b expected 1", cyc, busy);
      end
      if (cyc < stall) begin
        checks++;
        if (eps_ready !== 1'b1 || pg_issue !== 1'b0) begin
          errors++;
          $display("FAIL stall: cycle %0d eps_ready %b pg_issue %b, expected 1 0", cyc, eps_ready, pg_issue);
        end
      end
      if (restart && cyc == 2) begin
        start = 1'b1; num_paths = 16'(np + 3); num_days = 10'(nd + 1); strike = '0;
      end else begin
        start = 1'b0;
      end
      pg_result = (cyc == due) ? gp : 12'($urandom);
      eps_valid = (cyc >= stall) && ($urandom_range(1, 100) <= valid_pct);
      eps_data  = (eps_valid && ei < n_eps) ? eps_q[ei] : 13'($urandom);
      if (eps_valid && eps_ready === 1'b1) ei++;
      @(negedge clk);
    end
    eps_valid = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: no done within budget, issues %0d results %0d", issues, results);
    end else if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: after done got done %b busy %b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({eps_ready, pg_issue, pg_first_day, pg_epsilon, res_valid, res_price, res_path_idx,
         payoff_sum, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy %b done %b eps_ready %b sum %h, expected all 0",
               busy, done, eps_ready, payoff_sum);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || eps_ready !== 1'b0 || pg_issue !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: busy %b eps_ready %b pg_issue %b done %b, expected 0",
               busy, eps_ready, pg_issue, done);
    end
  endtask

  task automatic test_single();
    int fi, dc;
    run_case(1, 1, 12'h030, 12'h010, 0, 100, 0, 0, 0, fi, dc);
    checks++;
    if (fi != 1 || dc != LAT + 2 || payoff_sum !== 28'h20) begin
      errors++;
      $display("FAIL single: first issue %0d done %0d sum %h, expected 1 %0d 20", fi, dc, payoff_sum, LAT + 2);
    end
  endtask

  task automatic test_two_by_three();
    int fi, dc;
    run_case(2, 3, 12'($urandom), 12'($urandom), 63, 100, 0, 0, 0, fi, dc);
    checks++;
    if (fi != 1 || dc != 6 * (LAT + 2)) begin
      errors++;
      $display("FAIL two_by_three: first issue %0d done %0d, expected 1 %0d", fi, dc, 6 * (LAT + 2));
    end
  endtask

  task automatic test_payoff_edges();
    int fi, dc;
    run_case(1, 1, 12'h008, 12'h010, 0, 100, 0, 0, 0, fi, dc);
    checks++;
    if (payoff_sum !== '0) begin
      errors++;
      $display("FAIL below_strike: got %h expected 0", payoff_sum);
    end
    run_case(1, 1, 12'h010, 12'h010, 0, 100, 0, 0, 0, fi, dc);
    checks++;
    if (payoff_sum !== '0) begin
      errors++;
      $display("FAIL at_strike: got %h expected 0", payoff_sum);
    end
    run_case(1, 1, 12'h100, 12'h010, 0, 100, 0, 0, 0, fi, dc);
    repeat (6) @(negedge clk);
    checks++;
    if (payoff_sum !== 28'hF0) begin
      errors++;
      $display("FAIL idle_hold: got %h expected f0", payoff_sum);
    end
  endtask

  task automatic test_zero();
    int fi, dc;
    run_case(3, 0, 12'h200, 12'h001, 0, 100, 0, 0, 0, fi, dc);
    checks++;
    if (dc != 0 || fi != -1 || payoff_sum !== '0) begin
      errors++;
      $display("FAIL zero_days: done at %0d first issue %0d sum %h, expected 0 -1 0", dc, fi, payoff_sum);
    end
    run_case(0, 4, 12'h200, 12'h001, 0, 100, 0, 0, 0, fi, dc);
    checks++;
    if (dc != 0 || fi != -1) begin
      errors++;
      $display("FAIL zero_paths: done at %0d first issue %0d, expected 0 -1", dc, fi);
    end
  endtask

  task automatic test_stall();
    int fi, dc;
    run_case(2, 2, 12'($urandom), 12'($urandom), 63, 100, 20, 0, 0, fi, dc);
    checks++;
    if (fi != 21) begin
      errors++;
      $display("FAIL stall_resume: first issue at %0d expected 21", fi);
    end
  endtask

  task automatic test_restart_busy();
    int fi, dc;
    run_case(2, 2, 12'($urandom), 12'($urandom), 255, 100, 0, 1, 0, fi, dc);
  endtask

  task automatic test_abort();
    int fi, dc;
    bit bad;
    run_case(4, 2, 12'h300, 12'h100, 63, 100, 0, 0, 3, fi, dc);
    eps_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({eps_ready, pg_issue, pg_first_day, pg_epsilon, res_valid, res_price, res_path_idx,
         payoff_sum, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: busy %b done %b eps_ready %b sum %h idx %h, expected all 0",
               busy, done, eps_ready, payoff_sum, res_path_idx);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      eps_valid = 1'b1;
      if (done !== 1'b0 || busy !== 1'b0 || pg_issue !== 1'b0) bad = 1;
      @(negedge clk);
    end
    eps_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_quiet: activity after reset, done %b busy %b", done, busy);
    end
    run_case(2, 2, 12'($urandom), 12'($urandom), 63, 100, 0, 0, 0, fi, dc);
  endtask

  task automatic test_random();
    int fi, dc;
    for (int r = 0; r < 6; r++)
      run_case($urandom_range(1, 4), $urandom_range(1, 4), 12'($urandom), 12'($urandom),
               4095, $urandom_range(30, 100), 0, 0, 0, fi, dc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_paths = '0; num_days = '0; strike = '0;
    eps_valid = 1'b0; eps_data = '0; pg_result = '0;
    test_reset();
    test_single();
    test_two_by_three();
    test_payoff_edges();
    test_zero();
    test_stall();
    test_restart_busy();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
